// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------
// serial_tx
//
// UART-style 8N1 transmitter that feeds an FTDI receive pin. Bytes enter
// through a valid/ready handshake, wait in a small buffer, and are shifted
// out LSB first. Each frame is one start bit (0), eight data bits and one
// stop bit (1). Every bit lasts CLK_DIV clock cycles.
//
// Build option:
//   SERIAL_TX_FIFO_EN  when defined, the buffer is a 4-entry circular FIFO.
//                      When undefined (the default), the buffer is a single
//                      holding register.
//
// Parameters:
//   CLK_DIV   clk cycles per serial bit. The default of 26 gives 460800 baud
//             from a 12 MHz clock. Legal range is 2..65535.
//
// Ports:
//   clk       sole clock; all state changes happen on its rising edge
//   reset_n   asynchronous, active-low reset
//   tx_byte   byte to send; it is captured on the cycle it is accepted
//   tx_valid  tx_byte holds a valid byte this cycle
//   tx_ready  the block can accept a byte this cycle
//   tx        registered serial output; high when idle
//   tx_busy   a frame is in progress or a byte is waiting in the buffer
// ---------------------------------------------------------------------------
module serial_tx #(
  parameter int unsigned CLK_DIV = 26
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  // Frame state machine encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Terminal value of the per-bit cycle counter
  localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

  logic [1:0]  state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        tx_reg;

  logic        bit_end;
  logic        push;
  logic        pop;
  logic        buf_empty;
  logic        buf_full;
  logic [7:0]  buf_head;

  // bit_end marks the final cycle of the current bit period.
  // A pop moves the buffer head into the shifter. It happens when the line
  // is idle, or on the last stop-bit cycle so the next start bit follows
  // with no gap. Pop depends only on registered state, so tx_ready may
  // include it without creating a combinational loop through tx_valid.
  always_comb begin
    bit_end  = (bit_cnt == BIT_LAST);
    pop      = !buf_empty && ((state == IDLE) || ((state == STOP) && bit_end));
    tx_ready = !buf_full || pop;
    push     = tx_valid && tx_ready;
  end

`ifdef SERIAL_TX_FIFO_EN
  // Four-entry circular FIFO. The 2-bit pointers wrap from 3 to 0 on their
  // own, so a separate 3-bit count tells full apart from empty. When the
  // FIFO is full and a pop happens, the incoming byte is written into the
  // slot that is being vacated. The head is read combinationally before the
  // clock edge, so the outgoing byte is never lost.
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] fifo_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_mem[i] <= 8'h00;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= tx_byte;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Buffer status as seen by the handshake and the state machine
  always_comb begin
    buf_empty = (fifo_count == 3'd0);
    buf_full  = (fifo_count == 3'd4);
    buf_head  = fifo_mem[rd_ptr];
  end
`else
  // Single holding register. A push in the same cycle as a pop replaces the
  // byte that is leaving with the new one, so the register stays occupied.
  logic [7:0] hold_reg;
  logic       hold_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg   <= 8'h00;
      hold_valid <= 1'b0;
    end else begin
      if (push) begin
        hold_reg   <= tx_byte;
        hold_valid <= 1'b1;
      end else if (pop) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Buffer status as seen by the handshake and the state machine
  always_comb begin
    buf_empty = !hold_valid;
    buf_full  = hold_valid;
    buf_head  = hold_reg;
  end
`endif

  // Frame sequencer. The tx output is driven only from tx_reg, and tx_reg is
  // updated one edge ahead of each bit, so the line changes exactly on bit
  // boundaries. START drives bit 0 of the shifter as it leaves. Each DATA
  // bit boundary then shifts right and drives the next bit. That is why
  // DATA presents shift_reg[1] rather than shift_reg[0].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= 16'd0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      tx_reg    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= 16'd0;
          tx_reg  <= 1'b1;
          if (pop) begin
            shift_reg <= buf_head;
            tx_reg    <= 1'b0;
            state     <= START;
          end
        end

        START: begin
          if (bit_end) begin
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            tx_reg  <= shift_reg[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            bit_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              tx_reg <= 1'b1;
              state  <= STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_reg    <= shift_reg[1];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end

        STOP: begin
          if (bit_end) begin
            bit_cnt <= 16'd0;
            if (pop) begin
              shift_reg <= buf_head;
              tx_reg    <= 1'b0;
              state     <= START;
            end else begin
              tx_reg <= 1'b1;
              state  <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end

        default: begin
          state   <= IDLE;
          bit_cnt <= 16'd0;
          tx_reg  <= 1'b1;
        end
      endcase
    end
  end

  // Outputs: tx comes straight from a register. tx_busy is low only when the
  // line is idle and nothing is waiting to be sent.
  always_comb begin
    tx      = tx_reg;
    tx_busy = (state != IDLE) || !buf_empty;
  end

endmodule

// File: tb/tb_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_tx
//
// Self-checking bench for serial_tx with CLK_DIV=4.
//
// A frame-level reference model predicts tx, tx_ready and tx_busy on every
// cycle. It keeps a queue of pending bytes plus the current frame position.
// A line decoder turns tx back into bytes, which are compared against
// hand-written lists. Directed tests pin exact bit timings, accept cycles
// and the asynchronous reset response with literal values.
// ---------------------------------------------------------------------------
module tb_serial_tx;

  localparam int D     = 4;
  localparam int FRAME = 10 * D;
`ifdef SERIAL_TX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b1;
  logic [7:0] tx_byte  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;

  serial_tx #(.CLK_DIV(D)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Counts rising edges so tests can refer to absolute cycle numbers
  always @(posedge clk) cyc <= cyc + 1;

  // Single place where every comparison is counted and reported
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Records an expired wait as a failure without stopping the run
  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // ---------------- frame-level reference model ----------------
  logic [7:0] m_pend[$];
  logic [7:0] m_cur = 8'h00;
  bit         m_act = 1'b0;
  int         m_pos = 0;

  function automatic logic mTx();
    int b;
    if (!m_act) return 1'b1;
    b = m_pos / D;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  function automatic logic mPop();
    return (m_pend.size() > 0) && (!m_act || (m_pos == FRAME - 1));
  endfunction

  function automatic logic mReady();
    return (m_pend.size() < CAP) || mPop();
  endfunction

  function automatic logic mBusy();
    return m_act || (m_pend.size() > 0);
  endfunction

  // Advances the model on each rising edge; a low reset_n clears it at once
  initial begin
    logic pop_now;
    logic acc;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_pend.delete();
        m_act = 1'b0;
        m_pos = 0;
      end else begin
        pop_now = mPop();
        acc     = tx_valid && mReady();
        if (m_act) begin
          m_pos++;
          if (m_pos == FRAME) m_act = 1'b0;
        end
        if (pop_now) begin
          m_cur = m_pend.pop_front();
          m_act = 1'b1;
          m_pos = 0;
        end
        if (acc) m_pend.push_back(tx_byte);
      end
    end
  end

  // Compares the DUT against the model on every falling edge outside reset
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        checkOutput("model_tx", tx, mTx());
        checkOutput("model_ready", tx_ready, mReady());
        checkOutput("model_busy", tx_busy, mBusy());
      end
    end
  end

  // ---------------- line decoder ----------------
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  // Finds a start bit, samples each bit mid-period and checks the stop bit
  initial begin
    bit         rx_act = 1'b0;
    int         rx_k   = 0;
    logic [7:0] rx_sh  = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rx_act = 1'b0;
      end else if (!rx_act) begin
        if (tx == 1'b0) begin
          rx_act = 1'b1;
          rx_k   = 0;
          rx_sh  = 8'h00;
        end
      end else begin
        rx_k++;
        if ((rx_k % D == D / 2) && (rx_k / D >= 1) && (rx_k / D <= 8))
          rx_sh[rx_k / D - 1] = tx;
        if (rx_k == 9 * D + D / 2) begin
          checkOutput("stop_bit", tx, 1'b1);
          rx_q.push_back(rx_sh);
        end
        if (rx_k == FRAME - 1) rx_act = 1'b0;
      end
    end
  end

  // Compares decoded bytes against the expected list, then clears both
  task automatic checkRx(input string name);
    int n;
    checkOutput({name, "_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) checkOutput({name, "_byte"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus helpers ----------------
  logic [7:0] send_q[$];
  int         acc_cyc[$];

  // Presents every byte in send_q, holding tx_valid high until each one is
  // accepted, and records the rising-edge number of each accept
  task automatic applyStimulus();
    bit accepted;
    bit rdy;
    int waited;
    acc_cyc.delete();
    @(posedge clk);
    #1;
    foreach (send_q[i]) begin
      tx_byte  = send_q[i];
      tx_valid = 1'b1;
      accepted = 1'b0;
      waited   = 0;
      while (!accepted && waited < 300) begin
        @(negedge clk);
        rdy = tx_ready;
        @(posedge clk);
        #1;
        waited++;
        if (rdy) begin
          accepted = 1'b1;
          acc_cyc.push_back(cyc);
        end
      end
      if (!accepted) timeoutFail("accept_wait");
    end
    tx_valid = 1'b0;
    send_q.delete();
  endtask

  // Waits for the falling edge that follows rising edge number target
  task automatic waitNeg(input int target);
    @(negedge clk);
    while (cyc < target) @(negedge clk);
  endtask

  // Waits, with a bound, until nothing is in flight
  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (tx_busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeoutFail("idle_wait");
    repeat (2) @(negedge clk);
  endtask

  // Watchdog so the run always ends
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    int  a;
    logic a5_pat [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset must act without a clock edge
    #1 reset_n = 1'b0;
    #2;
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_busy", tx_busy, 1'b0);
    checkOutput("reset_ready", tx_ready, 1'b1);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    // 8'hA5 from idle: start bit on the next cycle, then LSB-first data
    $display("[TB] single byte A5");
    send_q = '{8'hA5};
    applyStimulus();
    a = acc_cyc[0];
    waitNeg(a);
    checkOutput("a5_pre_tx", tx, 1'b1);
    checkOutput("a5_pre_busy", tx_busy, 1'b1);
    for (int k = 1; k <= FRAME; k++) begin
      waitNeg(a + k);
      checkOutput("a5_bit", tx, a5_pat[(k - 1) / D]);
    end
    checkOutput("a5_busy_last", tx_busy, 1'b1);
    waitNeg(a + FRAME + 1);
    checkOutput("a5_busy_fall", tx_busy, 1'b0);
    exp_q = '{8'hA5};
    waitIdle();
    checkRx("a5_rx");

    // 8'h00 then 8'hFF with valid held: frames run back to back with no gap
    $display("[TB] back-to-back 00 FF");
    send_q = '{8'h00, 8'hFF};
    applyStimulus();
    a = acc_cyc[0];
    checkOutput("ff_accept_delta", acc_cyc[1] - a, 1);
    waitNeg(a + 1);
    checkOutput("b2b_start0", tx, 1'b0);
    waitNeg(a + 5);
    checkOutput("b2b_data0", tx, 1'b0);
    waitNeg(a + 37);
    checkOutput("b2b_stop0_first", tx, 1'b1);
    waitNeg(a + 40);
    checkOutput("b2b_stop0_last", tx, 1'b1);
    waitNeg(a + 41);
    checkOutput("b2b_start1", tx, 1'b0);
    waitNeg(a + 45);
    checkOutput("b2b_data1", tx, 1'b1);
    waitNeg(a + 80);
    checkOutput("b2b_stop1", tx, 1'b1);
    waitNeg(a + 81);
    checkOutput("b2b_busy_fall", tx_busy, 1'b0);
    exp_q = '{8'h00, 8'hFF};
    waitIdle();
    checkRx("b2b_rx");

`ifdef SERIAL_TX_FIFO_EN
    // Six bytes: one loads at once, four queue, the sixth waits for a pop
    $display("[TB] fifo burst of six");
    send_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    applyStimulus();
    checkOutput("fifo_acc2", acc_cyc[1] - acc_cyc[0], 1);
    checkOutput("fifo_acc5", acc_cyc[4] - acc_cyc[0], 4);
    checkOutput("fifo_acc6", acc_cyc[5] - acc_cyc[0], 41);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    waitIdle();
    checkRx("fifo_rx");
`else
    // Three bytes: the second follows at once, the third waits for its load
    $display("[TB] holding register, three bytes");
    send_q = '{8'h11, 8'h22, 8'h33};
    applyStimulus();
    checkOutput("hold_acc2", acc_cyc[1] - acc_cyc[0], 1);
    checkOutput("hold_acc3", acc_cyc[2] - acc_cyc[0], 41);
    exp_q = '{8'h11, 8'h22, 8'h33};
    waitIdle();
    checkRx("hold_rx");
`endif

    // A byte offered while tx_ready is low must vanish
    $display("[TB] dropped byte");
`ifdef SERIAL_TX_FIFO_EN
    send_q = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E};
`else
    send_q = '{8'h5A, 8'h6B};
`endif
    applyStimulus();
    @(negedge clk);
    checkOutput("drop_ready", tx_ready, 1'b0);
    #2;
    tx_byte  = 8'hEE;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
`ifdef SERIAL_TX_FIFO_EN
    exp_q = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E};
`else
    exp_q = '{8'h5A, 8'h6B};
`endif
    waitIdle();
    checkRx("drop_rx");

    // Reset in the middle of 8'h3C aborts it; 8'h81 then goes out cleanly
    $display("[TB] reset mid-frame");
    send_q = '{8'h3C};
    applyStimulus();
    a = acc_cyc[0];
    waitNeg(a + 10);
    checkOutput("mid_tx_low", tx, 1'b0);
    checkOutput("mid_busy", tx_busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_tx", tx, 1'b1);
    checkOutput("abort_busy", tx_busy, 1'b0);
    checkOutput("abort_ready", tx_ready, 1'b1);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    send_q = '{8'h81};
    applyStimulus();
    exp_q = '{8'h81};
    waitIdle();
    checkRx("post_reset_rx");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
